threefish_key_sched_ctrl: RTL

THREEFISH_KEY_SCHED_CTRL -- requirements
Module: threefish_key_sched_ctrl

---
 rtl/threefish_key_sched_ctrl_pkg.sv | 25 ++
 rtl/threefish_key_sched_ctrl_if.sv | 59 +++++
 rtl/threefish_key_sched_ctrl_wrap_counter.sv | 47 ++++
 rtl/threefish_key_sched_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/threefish_key_sched_ctrl_pkg.sv
// Shared definitions for the Threefish key-schedule controller.
//
// Holds:
//   - state_e              : controller FSM state encoding
//   - KeyBaseMax           : wrap point of the mod-9 extended-key word counter
//   - TweakSelMax          : wrap point of the mod-3 tweak word counters
//   - NumInjectDefault     : default number of subkey injections per block
//   - RoundsPerInjectDefault : default mix rounds between injections
package threefish_pkg;

    localparam int unsigned NumInjectDefault       = 19;
    localparam int unsigned RoundsPerInjectDefault = 4;

    // Last value before wrap-around; the counters count 0..Max.
    localparam int unsigned KeyBaseMax  = 8;  // s mod 9
    localparam int unsigned TweakSelMax = 2;  // s mod 3

    typedef enum logic [1:0] {
        StIdle,
        StInject,
        StRound,
        StDone
    } state_e;

endpackage

// File: rtl/threefish_key_sched_ctrl_if.sv
// Control/index bundle between the key-schedule controller and its user.
//
// Signals:
//   start_i        : request to process one block (user -> controller)
//   busy_o         : block in progress (INJECT/ROUND cycles)
//   inject_o       : add subkey s this cycle
//   round_en_o     : perform one mix round this cycle
//   subkey_idx_o   : current subkey index s
//   key_base_o     : s mod 9, first extended-key word of subkey s
//   tweak_sel_a_o  : s mod 3, tweak select for subkey word 5
//   tweak_sel_b_o  : (s+1) mod 3, tweak select for subkey word 6
//   round_idx_o    : current round d
//   rot_sel_o      : d mod 8, rotation-constant row
//   done_o         : one-cycle pulse after the final injection
//
// Modports: master = block user, slave = controller.
interface threefish_key_sched_ctrl_if;

    logic       start_i;
    logic       busy_o;
    logic       inject_o;
    logic       round_en_o;
    logic [4:0] subkey_idx_o;
    logic [3:0] key_base_o;
    logic [1:0] tweak_sel_a_o;
    logic [1:0] tweak_sel_b_o;
    logic [6:0] round_idx_o;
    logic [2:0] rot_sel_o;
    logic       done_o;

    modport master (
        output start_i,
        input  busy_o,
        input  inject_o,
        input  round_en_o,
        input  subkey_idx_o,
        input  key_base_o,
        input  tweak_sel_a_o,
        input  tweak_sel_b_o,
        input  round_idx_o,
        input  rot_sel_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        output busy_o,
        output inject_o,
        output round_en_o,
        output subkey_idx_o,
        output key_base_o,
        output tweak_sel_a_o,
        output tweak_sel_b_o,
        output round_idx_o,
        output rot_sel_o,
        output done_o
    );

endinterface

// File: rtl/threefish_key_sched_ctrl_wrap_counter.sv
// Incrementing counter that wraps from MAX back to 0.
//
// Parameters:
//   WIDTH : counter width
//   MAX   : last value before wrapping to 0
//   INIT  : value loaded on reset and on clr
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (loads INIT)
//   clr     : synchronous clear (loads INIT), lower priority than rst
//   en      : advance by one, wrapping MAX -> 0
//   count_o : current value
module wrap_counter #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = INIT;
        end else if (en) begin
            count_d = (count_q == MAX) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= INIT;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/threefish_key_sched_ctrl.sv
// Threefish key-schedule / round sequencing controller.
//
// Sequences one block as INJECT(s=0), ROUNDS_PER_INJECT x ROUND, INJECT(s=1), ...
// INJECT(s=NUM_INJECT-1), DONE, and publishes the subkey and round indices the
// datapath needs alongside the inject/round strobes.
//
// Parameters:
//   NUM_INJECT        : subkey injections per block (2..32)
//   ROUNDS_PER_INJECT : mix rounds between consecutive injections (>= 1)
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset, aborts any block without done
//   bus : control/index bundle (slave side), see threefish_key_sched_ctrl_if
module threefish_key_sched_ctrl
    import threefish_pkg::*;
#(
    parameter int unsigned NUM_INJECT        = NumInjectDefault,
    parameter int unsigned ROUNDS_PER_INJECT = RoundsPerInjectDefault
) (
    input  logic                        clk,
    input  logic                        rst,
    threefish_key_sched_ctrl_if.slave   bus
);

    localparam int unsigned RcWidth =
        (ROUNDS_PER_INJECT > 1) ? $clog2(ROUNDS_PER_INJECT) : 1;
    localparam logic [RcWidth-1:0] RcMax    = RcWidth'(ROUNDS_PER_INJECT - 1);
    localparam logic [4:0]         SubkeyMax = 5'(NUM_INJECT - 1);
    // Last round index of a block; round_idx saturates here.
    localparam logic [6:0]         RoundMax =
        7'((NUM_INJECT - 1) * ROUNDS_PER_INJECT - 1);

    state_e state_q;
    state_e state_d;

    logic accept;
    logic busy;
    logic inject;
    logic round_en;
    logic done;
    logic last_round;
    logic advance_s;

    logic [4:0]         subkey_idx;
    logic [3:0]         key_base;
    logic [1:0]         tweak_sel_a;
    logic [1:0]         tweak_sel_b;
    logic [2:0]         rot_sel;
    logic [RcWidth-1:0] round_cnt;
    logic [6:0]         round_idx_q;

    assign last_round = (round_cnt == RcMax);
    // s and its modular companions step together on the last round of a group.
    assign advance_s  = round_en & last_round;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        busy     = 1'b0;
        inject   = 1'b0;
        round_en = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    accept  = 1'b1;
                    state_d = StInject;
                end
            end
            StInject: begin
                busy    = 1'b1;
                inject  = 1'b1;
                state_d = (subkey_idx == SubkeyMax) ? StDone : StRound;
            end
            StRound: begin
                busy     = 1'b1;
                round_en = 1'b1;
                if (last_round) begin
                    state_d = StInject;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Index counters
    // ------------------------------------------------------------------
    wrap_counter #(
        .WIDTH (5),
        .MAX   (SubkeyMax),
        .INIT  (5'd0)
    ) u_subkey_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (advance_s),
        .count_o (subkey_idx)
    );

    wrap_counter #(
        .WIDTH (4),
        .MAX   (4'(KeyBaseMax)),
        .INIT  (4'd0)
    ) u_key_base_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (advance_s),
        .count_o (key_base)
    );

    wrap_counter #(
        .WIDTH (2),
        .MAX   (2'(TweakSelMax)),
        .INIT  (2'd0)
    ) u_tweak_a_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (advance_s),
        .count_o (tweak_sel_a)
    );

    // Runs one step ahead of tweak_sel_a: (s+1) mod 3.
    wrap_counter #(
        .WIDTH (2),
        .MAX   (2'(TweakSelMax)),
        .INIT  (2'd1)
    ) u_tweak_b_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (advance_s),
        .count_o (tweak_sel_b)
    );

    wrap_counter #(
        .WIDTH (3),
        .MAX   (3'd7),
        .INIT  (3'd0)
    ) u_rot_sel_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (round_en),
        .count_o (rot_sel)
    );

    // Rounds within the current group; restarted at every injection.
    wrap_counter #(
        .WIDTH (RcWidth),
        .MAX   (RcMax),
        .INIT  ('0)
    ) u_round_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept | inject),
        .en      (round_en),
        .count_o (round_cnt)
    );

    // Round index d, saturating so it still reads the last round in DONE/IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_idx_q <= 7'd0;
        end else if (accept) begin
            round_idx_q <= 7'd0;
        end else if (round_en && (round_idx_q != RoundMax)) begin
            round_idx_q <= round_idx_q + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy_o        = busy;
    assign bus.inject_o      = inject;
    assign bus.round_en_o    = round_en;
    assign bus.done_o        = done;
    assign bus.subkey_idx_o  = subkey_idx;
    assign bus.key_base_o    = key_base;
    assign bus.tweak_sel_a_o = tweak_sel_a;
    assign bus.tweak_sel_b_o = tweak_sel_b;
    assign bus.round_idx_o   = round_idx_q;
    assign bus.rot_sel_o     = rot_sel;

endmodule
